inc_rr_scheduler: RTL and testbench

- Shares one registered constant-increment datapath among NREQ requesters.
- Round-robin arbitration; one operation outstanding at a time.
- Each requester offers a WIDTH-bit operand on a valid/ready handshake.
- Result (operand + INCREMENT, modulo 2^WIDTH) returns on a single response channel, tagged with the requester index.
- Sits between client blocks and the shared increment stage; sequences and owns that stage.

---
 rtl/inc_rr_scheduler_pkg.sv | 19 +
 rtl/inc_stage.sv | 25 ++
 rtl/inc_rr_scheduler.sv | 106 ++++++++++
 tb/tb_inc_rr_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inc_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin increment scheduler.
// FSM encoding, default parameters and index-width helper.
package inc_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_INCREMENT = 5;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inc_stage.sv
// Shared constant-increment datapath stage.
// Registers din + INCREMENT (wrapping) when enabled.
module inc_stage #(
    parameter int WIDTH     = 8,
    parameter int INCREMENT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);

    // Result register; carry out of the top bit is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= din + INC;
        end
    end

endmodule

// File: rtl/inc_rr_scheduler.sv
// Round-robin scheduler sharing one increment stage among NREQ clients.
// One operation in flight: IDLE grants, EXEC computes, RESP returns.
module inc_rr_scheduler
    import inc_rr_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NREQ      = DEF_NREQ,
    parameter int INCREMENT = DEF_INCREMENT,
    localparam int IDW      = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             grant_found;
    logic [WIDTH-1:0] operand;

    // Pick the first valid requester after the last grant, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot ready, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst && state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sequencer: grant, run the shared stage, hold the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            id         <= '0;
            operand    <= '0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        operand    <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                        id         <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                        busy       <= 1'b1;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    inc_stage #(
        .WIDTH     (WIDTH),
        .INCREMENT (INCREMENT)
    ) u_inc_stage (
        .clk  (clk),
        .rst  (rst),
        .en   (state == EXEC),
        .din  (operand),
        .dout (rsp_data)
    );

    assign rsp_id = id;

endmodule

// File: tb/tb_inc_rr_scheduler.sv
// Testbench for inc_rr_scheduler: directed steps plus randomized traffic.
// Expected values come from a transaction-level round-robin model.
module tb_inc_rr_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int INC   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    always #5 clk = ~clk;

    inc_rr_scheduler #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .INCREMENT (INC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // model: phase 0 = waiting, 1 = computing, 2 = response pending
    int         m_phase;
    int         m_last;
    int         m_id;
    logic [7:0] m_res;
    int         cyc_n = 0;
    int         grant_q[$];
    int         gcyc_q[$];
    int         waitc[4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_last  = NREQ - 1;
        m_id    = 0;
        m_res   = 8'h00;
    endtask

    // One clock: check outputs against the model, take the edge, advance.
    task automatic cycle(output int granted);
        int         g;
        logic [3:0] er;
        granted = -1;
        #1;
        g  = pick(m_last, req_valid);
        er = (m_phase == 0 && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_res));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        @(posedge clk);
        cyc_n++;
        if (m_phase == 0) begin
            if (g >= 0) begin
                m_res   = 8'(int'(req_data[g*8 +: 8]) + INC);
                m_id    = g;
                m_last  = g;
                m_phase = 1;
                granted = g;
                grant_q.push_back(g);
                gcyc_q.push_back(cyc_n);
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic drain();
        int g;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        repeat (4) cycle(g);
    endtask

    initial begin
        int g;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        rsp_ready = 1'b1;
        rst       = 1'b0;
        model_reset();
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        @(posedge clk);
        #2;
        rst = 1'b1;

        // single request from requester 2
        req_valid = 4'b0100;
        req_data  = 32'h0010_0000;
        cycle(g);
        chk("t1_grant", 32'(g), 32'd2);
        req_valid = 4'b0000;
        cycle(g);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_data", 32'(rsp_data), 32'h15);
        chk("t1_rsp_id", 32'(rsp_id), 32'd2);
        cycle(g);
        cycle(g);

        // wrap-around arithmetic
        req_valid = 4'b0001;
        req_data  = 32'h0000_00FE;
        cycle(g);
        req_valid = 4'b0000;
        cycle(g);
        chk("t2_rsp_data", 32'(rsp_data), 32'h03);
        chk("t2_rsp_id", 32'(rsp_id), 32'd0);
        cycle(g);
        cycle(g);

        // fairness with all requesters active
        do_reset();
        grant_q.delete();
        gcyc_q.delete();
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && grant_q.size() < 5; n++) cycle(g);
        chk("t3_ngrants", 32'(grant_q.size()), 32'd5);
        if (grant_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t3_order", 32'(grant_q[k]), 32'(k % 4));
            end
            chk("t3_period", 32'(gcyc_q[4] - gcyc_q[0]), 32'd12);
        end
        drain();

        // response backpressure
        req_valid = 4'b0010;
        req_data  = 32'h0000_7700;
        cycle(g);
        req_valid = 4'b1101;
        rsp_ready = 1'b0;
        cycle(g);
        repeat (5) cycle(g);
        chk("t4_hold_data", 32'(rsp_data), 32'h7C);
        chk("t4_hold_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        cycle(g);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_valid", 32'(rsp_valid), 32'd0);
        drain();

        // reset during EXEC
        req_valid = 4'b0001;
        req_data  = 32'h0000_0042;
        cycle(g);
        rst = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        req_valid = 4'b1010;
        @(posedge clk);
        #2;
        rst = 1'b1;
        cycle(g);
        chk("t5_grant", 32'(g), 32'd1);
        req_valid = 4'b1000;
        cycle(g);
        drain();
        drain();

        // idle
        for (int n = 0; n < 10; n++) cycle(g);

        // randomized traffic
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(1) == 1) begin
                        req_valid[i]      = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                        waitc[i]          = 0;
                    end
                end else if (m_phase != 0 && $urandom_range(7) == 0) begin
                    req_valid[i] = 1'b0;
                    waitc[i]     = 0;
                end
            end
            rsp_ready = ($urandom_range(9) < 7);
            cycle(g);
            if (g >= 0) begin
                chk("fair_wait", 32'(waitc[g] <= NREQ - 1), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (i != g && req_valid[i]) waitc[i]++;
                end
                waitc[g]     = 0;
                req_valid[g] = 1'b0;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
